dispatch_ctrl: RTL and testbench

- Sits between `decode_unit` and the issue queues.
- Buffers decoded micro-ops in a small FIFO and routes each one, in program order, to the issue queue selected by its `iq_type`.
- Allocates branch tags and tracks unresolved branches, producing the `under_shadow` signal fed back to decode.
- Stalls dispatch when branch-tag resources are exhausted.

---
 rtl/dispatch_ctrl_if.sv | 33 +++
 rtl/dispatch_ctrl.sv | 112 +++++++++++
 tb/tb_dispatch_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_ctrl_if.sv
// Decode-to-dispatch and dispatch-to-issue handshake bundle for dispatch_ctrl.
// slave is the dispatch controller's view; master is the surrounding pipeline's view.
interface dispatch_ctrl_if #(
  parameter int NUM_IQ = 3,
  parameter int UOP_W  = 64,
  parameter int MAX_BR = 4
);
  localparam int BR_W = $clog2(MAX_BR);

  logic              in_valid;
  logic              in_ready;
  logic [UOP_W-1:0]  in_uop;
  logic [1:0]        in_iq_type;
  logic              in_is_br;
  logic              in_is_jalr;
  logic              in_shadowable;

  logic [NUM_IQ-1:0] iq_valid;
  logic [NUM_IQ-1:0] iq_ready;
  logic [UOP_W-1:0]  iq_uop;
  logic [BR_W-1:0]   iq_br_tag;
  logic              iq_under_shadow;

  modport slave (
    input  in_valid, in_uop, in_iq_type, in_is_br, in_is_jalr, in_shadowable, iq_ready,
    output in_ready, iq_valid, iq_uop, iq_br_tag, iq_under_shadow
  );

  modport master (
    output in_valid, in_uop, in_iq_type, in_is_br, in_is_jalr, in_shadowable, iq_ready,
    input  in_ready, iq_valid, iq_uop, iq_br_tag, iq_under_shadow
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// In-order dispatch: small uop FIFO, routing to issue queues, branch tag allocation.
// Optional DISPATCH_SHADOW_STALL_EN holds non-shadowable uops while branches are unresolved.
module dispatch_ctrl #(
  parameter int NUM_IQ    = 3,
  parameter int MAX_BR    = 4,   // power of 2
  parameter int BUF_DEPTH = 2,   // power of 2, >= 2
  parameter int UOP_W     = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  dispatch_ctrl_if.slave bus,
  input  logic           br_resolve,
  input  logic           flush,
  output logic           under_shadow,
  output logic           illegal_iq
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int BR_W  = $clog2(MAX_BR);
  localparam int CNT_W = BR_W + 1;

  localparam logic [2:0] S_EMPTY        = 3'd0;
  localparam logic [2:0] S_REQ          = 3'd1;
  localparam logic [2:0] S_BR_STALL     = 3'd2;
  localparam logic [2:0] S_DROP         = 3'd3;
  localparam logic [2:0] S_SHADOW_STALL = 3'd4;

  typedef struct packed {
    logic [UOP_W-1:0] uop;
    logic [1:0]       iq_type;
    logic             is_br;       // is_br | is_jalr
    logic             shadowable;
  } entry_t;

  entry_t           mem [BUF_DEPTH];
  entry_t           head;
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0] br_count;
  logic [BR_W-1:0]  br_alloc_ptr;
  logic [2:0]       state;
  logic             empty, full, push, pop, fire, br_fire, resolve;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head         = mem[rd_ptr[PTR_W-1:0]];
  assign bus.in_ready = !full;
  assign under_shadow = (br_count != '0);
  assign push         = bus.in_valid && !full && !flush;

  always_comb begin
    state = S_REQ;
    if (empty)
      state = S_EMPTY;
    else if (head.is_br && br_count == CNT_W'(MAX_BR))
      state = S_BR_STALL;
    else if (int'(head.iq_type) >= NUM_IQ)
      state = S_DROP;
`ifdef DISPATCH_SHADOW_STALL_EN
    else if (!head.shadowable && under_shadow)
      state = S_SHADOW_STALL;
`endif
  end

`ifndef DISPATCH_SHADOW_STALL_EN
  logic unused_shadowable;
  assign unused_shadowable = head.shadowable;
`endif

  for (genvar i = 0; i < NUM_IQ; i++) begin : g_iq
    assign bus.iq_valid[i] = (state == S_REQ) && !flush && (int'(head.iq_type) == i);
  end

  assign fire       = |(bus.iq_valid & bus.iq_ready);
  assign br_fire    = fire && head.is_br;
  assign illegal_iq = (state == S_DROP) && !flush;
  assign pop        = fire || illegal_iq;
  assign resolve    = br_resolve && under_shadow;

  // Payload is held by the FIFO head itself, so it stays stable until popped.
  assign bus.iq_uop          = empty ? '0 : head.uop;
  assign bus.iq_under_shadow = !empty && under_shadow;
  assign bus.iq_br_tag       = empty        ? '0 :
                               head.is_br   ? br_alloc_ptr :
                               under_shadow ? br_alloc_ptr - BR_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PTR_W-1:0]] <= {bus.in_uop, bus.in_iq_type,
                                 bus.in_is_br | bus.in_is_jalr, bus.in_shadowable};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      br_count     <= '0;
      br_alloc_ptr <= '0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      br_count     <= '0;
      br_alloc_ptr <= '0;
    end else begin
      if (push)    wr_ptr       <= wr_ptr + 1'b1;
      if (pop)     rd_ptr       <= rd_ptr + 1'b1;
      if (br_fire) br_alloc_ptr <= br_alloc_ptr + 1'b1;
      // Allocation and resolution in one cycle cancel out on the count.
      if (br_fire && !resolve)      br_count <= br_count + 1'b1;
      else if (!br_fire && resolve) br_count <= br_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed, table-driven bench for dispatch_ctrl plus hand-written multi-cycle sequences.
module tb_dispatch_ctrl;
  localparam int NUM_IQ = 3, MAX_BR = 4, BUF_DEPTH = 2, UOP_W = 64;

  logic clk = 1'b0, rst_n = 1'b0, br_resolve = 1'b0, flush = 1'b0;
  logic under_shadow, illegal_iq;
  int   n_cmp = 0, n_bad = 0;

  dispatch_ctrl_if #(.NUM_IQ(NUM_IQ), .UOP_W(UOP_W), .MAX_BR(MAX_BR)) bus();

  dispatch_ctrl #(.NUM_IQ(NUM_IQ), .MAX_BR(MAX_BR), .BUF_DEPTH(BUF_DEPTH), .UOP_W(UOP_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .br_resolve(br_resolve), .flush(flush),
    .under_shadow(under_shadow), .illegal_iq(illegal_iq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [63:0] uop;
    logic [1:0]  typ;
    logic        br, jalr, shad;
    logic [2:0]  rdy;
    logic        res, fl;
    logic [2:0]  ev;
    logic [63:0] euop;
    logic [1:0]  etag;
    logic        eish, eus, erdy, eill;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] pl(input int k);
    return {k[31:0] ^ 32'h5A5A_0000, ~k[31:0]};
  endfunction

  task automatic add(input logic vld, input logic [63:0] uop, input logic [1:0] typ,
                     input logic br, input logic jalr, input logic shad, input logic [2:0] rdy,
                     input logic res, input logic fl, input logic [2:0] ev, input logic [63:0] euop,
                     input logic [1:0] etag, input logic eish, input logic eus, input logic erdy,
                     input logic eill);
    vec_t v;
    v.vld = vld; v.uop = uop; v.typ = typ; v.br = br; v.jalr = jalr; v.shad = shad;
    v.rdy = rdy; v.res = res; v.fl = fl; v.ev = ev; v.euop = euop; v.etag = etag;
    v.eish = eish; v.eus = eus; v.erdy = erdy; v.eill = eill;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [63:0] uop, input logic [1:0] typ,
                       input logic br, input logic jalr, input logic shad, input logic [2:0] rdy,
                       input logic res, input logic fl);
    bus.in_valid = vld; bus.in_uop = uop; bus.in_iq_type = typ; bus.in_is_br = br;
    bus.in_is_jalr = jalr; bus.in_shadowable = shad; bus.iq_ready = rdy;
    br_resolve = res; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(0, '0, 0, 0, 0, 1, 3'b111, 0, 0);
    #12;
    chk("reset iq_valid", bus.iq_valid, 0);
    chk("reset under_shadow", under_shadow, 0);
    chk("reset illegal_iq", illegal_iq, 0);
    chk("reset iq_uop", bus.iq_uop, 0);
    chk("reset iq_br_tag", bus.iq_br_tag, 0);
    #1 rst_n = 1'b1;
    cyc();
    chk("post-reset in_ready", bus.in_ready, 1);

    // 4 back-to-back ALU uops
    add(1, pl(1), 0, 0, 0, 1, 7, 0, 0,  0, 0,     0, 0, 0, 1, 0);
    add(1, pl(2), 0, 0, 0, 1, 7, 0, 0,  1, pl(1), 0, 0, 0, 1, 0);
    add(1, pl(3), 0, 0, 0, 1, 7, 0, 0,  1, pl(2), 0, 0, 0, 1, 0);
    add(1, pl(4), 0, 0, 0, 1, 7, 0, 0,  1, pl(3), 0, 0, 0, 1, 0);
    add(0, 0,     0, 0, 0, 1, 7, 0, 0,  1, pl(4), 0, 0, 0, 1, 0);
    add(0, 0,     0, 0, 0, 1, 7, 0, 0,  0, 0,     0, 0, 0, 1, 0);
    // 5 branches into queue 1; the 5th waits for a free tag
    add(1, pl(10), 1, 1, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    add(1, pl(11), 1, 1, 0, 1, 7, 0, 0,  2, pl(10), 0, 0, 0, 1, 0);
    add(1, pl(12), 1, 1, 0, 1, 7, 0, 0,  2, pl(11), 1, 1, 1, 1, 0);
    add(1, pl(13), 1, 0, 1, 1, 7, 0, 0,  2, pl(12), 2, 1, 1, 1, 0);
    add(1, pl(14), 1, 1, 0, 1, 7, 0, 0,  2, pl(13), 3, 1, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  0, 0,      0, 0, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 1, 0,  0, 0,      0, 0, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  2, pl(14), 0, 1, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 1,  0, 0,      0, 0, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    // queue 1 back-pressured for 3 cycles, FIFO fills
    add(1, pl(20), 1, 0, 0, 1, 5, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    add(1, pl(21), 0, 0, 0, 1, 5, 0, 0,  2, pl(20), 0, 0, 0, 1, 0);
    add(1, pl(22), 0, 0, 0, 1, 5, 0, 0,  2, pl(20), 0, 0, 0, 0, 0);
    add(0, 0,      0, 0, 0, 1, 5, 0, 0,  2, pl(20), 0, 0, 0, 0, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  2, pl(20), 0, 0, 0, 0, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  1, pl(21), 0, 0, 0, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    // illegal queue index dropped, next uop dispatches
    add(1, pl(30), 3, 0, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    add(1, pl(31), 2, 0, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 1);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  4, pl(31), 0, 0, 0, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    // flush with resolve and enqueue while 2 branches outstanding
    add(1, pl(40), 0, 1, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    add(1, pl(41), 0, 1, 0, 1, 7, 0, 0,  1, pl(40), 0, 0, 0, 1, 0);
    add(1, pl(42), 0, 1, 0, 1, 7, 0, 0,  1, pl(41), 1, 1, 1, 1, 0);
    add(1, pl(43), 0, 1, 0, 1, 7, 1, 1,  0, 0,      0, 0, 1, 1, 0);
    add(1, pl(44), 0, 1, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  1, pl(44), 0, 0, 0, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 1,  0, 0,      0, 0, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    // dispatch+resolve same cycle, then resolve with nothing outstanding
    add(1, pl(50), 2, 1, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    add(1, pl(51), 2, 1, 0, 1, 7, 0, 0,  4, pl(50), 0, 0, 0, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 1, 0,  4, pl(51), 1, 1, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 1, 0,  0, 0,      0, 0, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 1, 0,  0, 0,      0, 0, 0, 1, 0);
    add(1, pl(52), 2, 1, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  4, pl(52), 2, 0, 0, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 1,  0, 0,      0, 0, 1, 1, 0);
    add(0, 0,      0, 0, 0, 1, 7, 0, 0,  0, 0,      0, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].uop, tbl[i].typ, tbl[i].br, tbl[i].jalr, tbl[i].shad,
            tbl[i].rdy, tbl[i].res, tbl[i].fl);
      #2;
      chk($sformatf("row%0d iq_valid", i), bus.iq_valid, tbl[i].ev);
      chk($sformatf("row%0d under_shadow", i), under_shadow, tbl[i].eus);
      chk($sformatf("row%0d in_ready", i), bus.in_ready, tbl[i].erdy);
      chk($sformatf("row%0d illegal_iq", i), illegal_iq, tbl[i].eill);
      if (tbl[i].ev != 3'b000) begin
        chk($sformatf("row%0d iq_uop", i), bus.iq_uop, tbl[i].euop);
        chk($sformatf("row%0d iq_br_tag", i), bus.iq_br_tag, tbl[i].etag);
        chk($sformatf("row%0d iq_under_shadow", i), bus.iq_under_shadow, tbl[i].eish);
      end
      cyc();
    end

    // branch followed by a non-shadowable store
    drive(1, pl(60), 0, 1, 0, 1, 7, 0, 0);
    #2 chk("shadow br enq iq_valid", bus.iq_valid, 0);
    cyc();
    drive(1, pl(61), 2, 0, 0, 0, 7, 0, 0);
    #2 chk("shadow br iq_valid", bus.iq_valid, 3'b001);
    chk("shadow br tag", bus.iq_br_tag, 0);
    cyc();
    drive(0, '0, 0, 0, 0, 1, 7, 0, 0);
`ifdef DISPATCH_SHADOW_STALL_EN
    #2 chk("store held iq_valid", bus.iq_valid, 0);
    chk("store held under_shadow", under_shadow, 1);
    br_resolve = 1'b1;
    cyc();
    br_resolve = 1'b0;
    #2 chk("store release iq_valid", bus.iq_valid, 3'b100);
    chk("store release iq_uop", bus.iq_uop, pl(61));
    chk("store release iq_under_shadow", bus.iq_under_shadow, 0);
`else
    #2 chk("store iq_valid", bus.iq_valid, 3'b100);
    chk("store iq_uop", bus.iq_uop, pl(61));
    chk("store iq_under_shadow", bus.iq_under_shadow, 1);
`endif
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // asynchronous reset while a request is pending
    drive(1, pl(70), 0, 0, 0, 1, 3'b000, 0, 0);
    #2 chk("pre-reset enq iq_valid", bus.iq_valid, 0);
    cyc();
    bus.in_valid = 1'b0;
    #2 chk("pending req iq_valid", bus.iq_valid, 3'b001);
    #1 rst_n = 1'b0;
    #1 chk("async reset iq_valid", bus.iq_valid, 0);
    chk("async reset iq_uop", bus.iq_uop, 0);
    #2 rst_n = 1'b1;
    bus.iq_ready = 3'b111;
    cyc();
    #2 chk("after reset iq_valid", bus.iq_valid, 0);
    chk("after reset in_ready", bus.in_ready, 1);
    chk("after reset under_shadow", under_shadow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
